// File: rtl/cron_bcd.sv
// ============================================================================
// cron_bcd : multi-digit BCD stopwatch with prescaler, lap hold, wrap/saturate
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module cron_bcd #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 10,
   parameter bit WRAP     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl,
   input  logic                  clr,
   input  logic                  lap,
   output logic                  running,
   output logic [4*DIGITS-1:0]   disp,
   output logic                  ovf
);

   localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

   logic [4*DIGITS-1:0] count;
   logic [4*DIGITS-1:0] lap_reg;
   logic [4*DIGITS-1:0] count_inc;
   logic                lap_hold;
   logic [PW-1:0]       presc;
   logic                ctrl_q;
   logic                lap_q;

   logic [DIGITS:0]     carry;
   logic                all9;
   logic                press;
   logic                lpress;
   logic                tick;
   logic                press_blocked;

   // Ripple carry through the digits; carry out of the top digit means all-9s.
   assign carry[0] = 1'b1;

   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         logic [3:0] d;
         logic       nine;
         assign d    = count[4*k +: 4];
         assign nine = (d == 4'd9);
         assign count_inc[4*k +: 4] = !carry[k] ? d : (nine ? 4'd0 : d + 4'd1);
         assign carry[k+1] = carry[k] & nine;
      end
   endgenerate

   assign all9          = carry[DIGITS];
   assign press         = ctrl & ~ctrl_q;
   assign lpress        = lap & ~lap_q;
   assign tick          = running & (presc == PRESC_LAST);
   // A saturated counter refuses to restart until it has been cleared.
   assign press_blocked = !WRAP && all9 && !clr;

   always_ff @(posedge clk) begin
      if (rst) begin
         running  <= 1'b0;
         count    <= '0;
         lap_reg  <= '0;
         lap_hold <= 1'b0;
         presc    <= '0;
         ctrl_q   <= 1'b0;
         lap_q    <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         ctrl_q <= ctrl;
         lap_q  <= lap;
         ovf    <= 1'b0;

         if (clr) begin
            count    <= '0;
            presc    <= '0;
            lap_hold <= 1'b0;
         end else begin
            if (running)
               presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);

            if (tick) begin
               if (!all9) begin
                  count <= count_inc;
               end else begin
                  ovf <= 1'b1;
                  if (WRAP)
                     count <= '0;
                  else
                     running <= 1'b0;
               end
            end

            if (lpress) begin
               if (!lap_hold) begin
                  lap_reg  <= count;
                  lap_hold <= 1'b1;
               end else begin
                  lap_hold <= 1'b0;
               end
            end
         end

         if (press && !press_blocked)
            running <= ~running;
      end
   end

   assign disp = lap_hold ? lap_reg : count;

endmodule

`default_nettype wire

// File: tb/tb_cron_bcd.sv
// Scoreboard bench for cron_bcd: three instances (WRAP=1, WRAP=0, TICK_DIV=1)
// share stimulus and are checked every cycle against a decimal reference model.
`default_nettype none

module tb_cron_bcd;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ctrl = 1'b0;
   logic clr = 1'b0;
   logic lap = 1'b0;

   logic       run_a, run_b, run_c;
   logic       ovf_a, ovf_b, ovf_c;
   logic [7:0] disp_a, disp_b, disp_c;

   always #5 clk = ~clk;

   cron_bcd #(.DIGITS(2), .TICK_DIV(3), .WRAP(1'b1)) dut_a (
      .clk(clk), .rst(rst), .ctrl(ctrl), .clr(clr), .lap(lap),
      .running(run_a), .disp(disp_a), .ovf(ovf_a));

   cron_bcd #(.DIGITS(2), .TICK_DIV(3), .WRAP(1'b0)) dut_b (
      .clk(clk), .rst(rst), .ctrl(ctrl), .clr(clr), .lap(lap),
      .running(run_b), .disp(disp_b), .ovf(ovf_b));

   cron_bcd #(.DIGITS(2), .TICK_DIV(1), .WRAP(1'b1)) dut_c (
      .clk(clk), .rst(rst), .ctrl(ctrl), .clr(clr), .lap(lap),
      .running(run_c), .disp(disp_c), .ovf(ovf_c));

   int n_cmp = 0;
   int n_bad = 0;

   int TD[3] = '{3, 3, 1};
   int WR[3] = '{1, 0, 1};
   int m_run[3], m_cnt[3], m_lap[3], m_hold[3], m_presc[3], m_cq[3], m_lq[3], m_ovf[3];

   logic [9:0] sb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [9:0] expect_of(input int i);
      int d;
      d = (m_hold[i] != 0) ? m_lap[i] : m_cnt[i];
      return {1'(m_ovf[i]), 1'(m_run[i]), to_bcd(d)};
   endfunction

   task automatic step(input int i);
      int press, lp, all9, tick;
      int nr, nc, np, nh, nl, no;
      if (rst) begin
         m_run[i] = 0; m_cnt[i] = 0; m_lap[i] = 0; m_hold[i] = 0;
         m_presc[i] = 0; m_cq[i] = 0; m_lq[i] = 0; m_ovf[i] = 0;
         return;
      end
      press = (ctrl && m_cq[i] == 0) ? 1 : 0;
      lp    = (lap && m_lq[i] == 0) ? 1 : 0;
      all9  = (m_cnt[i] == 99) ? 1 : 0;
      tick  = (m_run[i] != 0 && m_presc[i] == TD[i] - 1) ? 1 : 0;
      nr = m_run[i]; nc = m_cnt[i]; np = m_presc[i];
      nh = m_hold[i]; nl = m_lap[i]; no = 0;
      if (clr) begin
         nc = 0; np = 0; nh = 0;
      end else begin
         if (m_run[i] != 0) np = (m_presc[i] + 1) % TD[i];
         if (tick != 0) begin
            if (all9 == 0) nc = m_cnt[i] + 1;
            else begin
               no = 1;
               if (WR[i] != 0) nc = 0;
               else nr = 0;
            end
         end
         if (lp != 0) begin
            if (m_hold[i] == 0) begin nl = m_cnt[i]; nh = 1; end
            else nh = 0;
         end
      end
      if (press != 0 && !(WR[i] == 0 && all9 != 0 && !clr)) nr = (m_run[i] != 0) ? 0 : 1;
      m_run[i] = nr; m_cnt[i] = nc; m_presc[i] = np; m_hold[i] = nh;
      m_lap[i] = nl; m_ovf[i] = no; m_cq[i] = ctrl; m_lq[i] = lap;
   endtask

   task automatic cyc();
      for (int i = 0; i < 3; i++) begin
         step(i);
         sb.push_back(expect_of(i));
      end
      @(posedge clk);
      #1;
      check("sb_a", {22'b0, ovf_a, run_a, disp_a}, 32'(sb.pop_front()));
      check("sb_b", {22'b0, ovf_b, run_b, disp_b}, 32'(sb.pop_front()));
      check("sb_c", {22'b0, ovf_c, run_c, disp_c}, 32'(sb.pop_front()));
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      cyc(); cyc();
      check("rst_disp", disp_a, 8'h00);
      check("rst_run", run_a, 0);
      check("rst_ovf", ovf_a, 0);

      // 1: start, counting cadence, held ctrl toggles once
      rst = 1'b0; ctrl = 1'b1; cyc(); ctrl = 1'b0;
      check("p1_run", run_a, 1);
      repeat (3) cyc();
      check("p1_d01", disp_a, 8'h01);
      repeat (3) cyc();
      check("p1_d02", disp_a, 8'h02);
      ctrl = 1'b1; repeat (10) cyc(); ctrl = 1'b0;
      check("p1_held", run_a, 0);
      cyc(); ctrl = 1'b1; cyc(); ctrl = 1'b0;
      check("p1_resume", run_a, 1);

      // 2: overflow, wrap versus saturate
      for (int k = 0; k < 400 && m_ovf[0] == 0; k++) cyc();
      check("p2_reach", m_ovf[0], 1);
      check("p2_wrap_disp", disp_a, 8'h00);
      check("p2_wrap_run", run_a, 1);
      check("p2_wrap_ovf", ovf_a, 1);
      check("p2_sat_disp", disp_b, 8'h99);
      check("p2_sat_run", run_b, 0);
      check("p2_sat_ovf", ovf_b, 1);
      cyc();
      check("p2_ovf_pulse_a", ovf_a, 0);
      check("p2_ovf_pulse_b", ovf_b, 0);
      ctrl = 1'b1; cyc(); ctrl = 1'b0;
      check("p2_sat_ignore", run_b, 0);
      cyc();
      clr = 1'b1; cyc(); clr = 1'b0;
      ctrl = 1'b1; cyc(); ctrl = 1'b0;
      check("p2_sat_restart_run", run_b, 1);
      check("p2_sat_restart_disp", disp_b, 8'h00);

      // 3: pause mid-period, resume continues partial period
      rst = 1'b1; cyc(); rst = 1'b0;
      ctrl = 1'b1; cyc(); ctrl = 1'b0;
      cyc();
      ctrl = 1'b1; cyc(); ctrl = 1'b0;
      repeat (20) cyc();
      check("p3_frozen", disp_a, 8'h00);
      check("p3_paused", run_a, 0);
      ctrl = 1'b1; cyc(); ctrl = 1'b0;
      check("p3_resume_disp", disp_a, 8'h00);
      cyc();
      check("p3_next_inc", disp_a, 8'h01);

      // 4: lap hold
      clr = 1'b1; cyc(); clr = 1'b0;
      for (int k = 0; k < 100 && m_cnt[0] != 7; k++) cyc();
      lap = 1'b1; cyc(); lap = 1'b0;
      check("p4_lap07", disp_a, 8'h07);
      for (int k = 0; k < 100 && !(m_cnt[0] == 12 && m_presc[0] == 0); k++) cyc();
      check("p4_held07", disp_a, 8'h07);
      lap = 1'b1; cyc(); lap = 1'b0;
      check("p4_release12", disp_a, 8'h12);
      cyc();
      lap = 1'b1; cyc(); lap = 1'b0;
      check("p4_lap12", disp_a, 8'h12);
      clr = 1'b1; cyc(); clr = 1'b0;
      check("p4_clr_disp", disp_a, 8'h00);

      // 5: clear in a tick cycle
      for (int k = 0; k < 400 && !(m_cnt[0] == 45 && m_presc[0] == 2 && m_run[0] != 0); k++) cyc();
      check("p5_reach", m_cnt[0], 45);
      clr = 1'b1; cyc(); clr = 1'b0;
      check("p5_disp", disp_a, 8'h00);
      check("p5_ovf", ovf_a, 0);
      check("p5_run", run_a, 1);
      cyc(); cyc();
      check("p5_still0", disp_a, 8'h00);
      cyc();
      check("p5_inc", disp_a, 8'h01);

      // 6: reset mid-count with lap held and prescaler nonzero
      lap = 1'b1; cyc(); lap = 1'b0; cyc();
      for (int k = 0; k < 10 && m_presc[0] == 0; k++) cyc();
      rst = 1'b1; cyc(); rst = 1'b0;
      check("p6_disp", disp_a, 8'h00);
      check("p6_run", run_a, 0);
      check("p6_ovf", ovf_a, 0);
      check("p6_run_c", run_c, 0);
      ctrl = 1'b1; cyc(); ctrl = 1'b0;
      cyc();
      check("p6_c01", disp_c, 8'h01);
      cyc();
      check("p6_c02", disp_c, 8'h02);
      repeat (30) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cron_bcd.md
Name: cron_bcd

Overview:
- Parametrised multi-digit BCD stopwatch; successor to the single-digit 0–9 stopwatch.
- Adds:
  - configurable digit count;
  - clock prescaler for the count rate;
  - edge-detected start/stop;
  - clear;
  - lap-hold display;
  - wrap or saturate mode with overflow flag.
- Sits between debounced button inputs and the 7-segment decoder/mux.

Parameters:
- DIGITS, 4, number of BCD digits (>=1); digit 0 is least significant.
- TICK_DIV, 10, clk cycles per count increment while running (>=1).
- WRAP, 1, 1 = roll over from all-9s to all-0s and keep running; 0 = saturate at all-9s and stop.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ctrl  in  1  start/stop; a rising edge toggles run/pause
- clr  in  1  synchronous clear of count, level-sensitive
- lap  in  1  lap; a rising edge toggles lap-hold
- running  out  1  1 while counting
- disp  out  4*DIGITS  BCD value to display; digit k at bits [4k+3:4k]
- ovf  out  1  one-cycle pulse on wrap or saturation

Behaviour:
- Registers: running, count[4*DIGITS], lap_reg[4*DIGITS], lap_hold, presc, ctrl_q, lap_q, ovf.
- All outputs are registered or driven from registers; no combinational path from inputs to outputs.
- Reset (rst=1 at a clk edge): all registers cleared to 0.
  - Gives running=0, disp=0, ovf=0.
  - rst has priority over everything.
- Edge detect: press = ctrl & ~ctrl_q; lpress = lap & ~lap_q.
  - ctrl_q and lap_q update every non-reset cycle.
  - ctrl held high across reset release counts as a press on the first post-reset cycle.
- Run state: press toggles running.
  - Exception: WRAP=0 with count all-9s. A press is ignored (running stays 0) until clr.
- Prescaler:
  - While running, presc counts 0..TICK_DIV-1 and wraps.
  - tick = running & (presc == TICK_DIV-1).
  - While paused, presc holds, so resume continues the partial period.
  - TICK_DIV=1 gives tick on every running cycle.
- Increment on tick:
  - Digit 0 +1. A digit at 9 becomes 0 and carries to the next digit.
  - Digits never hold values 10–15.
- All-9s at tick:
  - WRAP=1: count becomes 0, ovf=1 for one cycle, running stays 1.
  - WRAP=0: count holds all-9s, ovf=1 for one cycle, running cleared to 0 on the same edge.
- ovf is 0 on every other cycle.
- Clear (clr=1, rst=0):
  - count, presc and lap_hold go to 0.
  - running unchanged (clearing while running restarts from 0).
  - clr wins over a simultaneous tick; no ovf.
  - A simultaneous ctrl press is still applied.
- Lap:
  - lpress with lap_hold=0: lap_reg <= current count (pre-tick value of that cycle), lap_hold <= 1.
  - lpress with lap_hold=1: lap_hold <= 0.
  - Counting continues underneath in either case.
  - lap is honoured while paused.
- Display: disp = lap_hold ? lap_reg : count.
- Latency:
  - disp shows the incremented count from the edge after the tick cycle.
  - running changes on the edge that samples the press.
  - A press and tick in the same cycle: tick uses the pre-press running value.

Test Plan (DIGITS=2, TICK_DIV=3, WRAP=1 unless noted):
1. Reset, then one-cycle ctrl pulse:
   - running=1 next cycle.
   - disp 00→01→02 every 3 cycles.
   - ctrl held high 10 cycles gives exactly one toggle.
2. Run to 99, then next tick:
   - disp=00, ovf high exactly 1 cycle, running stays 1.
   - With WRAP=0: disp stays 99, running=0, ovf one pulse.
   - Later ctrl press is ignored; clr then ctrl resumes from 00.
3. Pause after 1 of 3 prescale cycles, wait 20 cycles, resume:
   - disp frozen while paused.
   - Next increment arrives 2 cycles after resume.
4. Lap press at count 07:
   - disp holds 07 while count advances to 12.
   - Second lap press: disp=12 next cycle.
   - clr while lap-held: disp=00, lap_hold=0.
5. clr asserted in a tick cycle at count 45 while running:
   - disp=00, ovf=0, running=1.
   - Next increment 3 cycles later.
6. rst mid-count with lap_hold=1 and presc nonzero:
   - Next cycle: disp=00, running=0, ovf=0.
   - TICK_DIV=1 run: disp increments every cycle.
